// File: rtl/adc_frame_controller.sv
// Frame controller for NUM_CH parallel serial ADCs sharing one chip-select and SPI clock.
// Captures all channels in lock-step and streams the words out one channel at a time.
module adc_frame_controller #(
  parameter int NUM_CH        = 4,
  parameter int DATA_BITS     = 10,
  parameter int NULL_BITS     = 3,
  parameter int GAP_CYCLES    = 2,
  parameter int PERIOD_CYCLES = 20,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 enable,
  input  logic                 ovr_clr,
  input  logic [NUM_CH-1:0]    adc_data,
  output logic                 cs,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [CH_W-1:0]      out_channel,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NULLS = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [CNT_W-1:0]     period_cnt_r;
  logic                 start_s;
  logic                 cs_s;
  logic                 shift_en_s;
  logic                 complete_s;

  logic [DATA_BITS-1:0] shreg_r [NUM_CH];
  logic [DATA_BITS-1:0] word_s  [NUM_CH];
  logic [DATA_BITS-1:0] buf_r   [NUM_CH];

  logic                 cs_r;
  logic                 busy_r;
  logic                 out_valid_r;
  logic [DATA_BITS-1:0] out_data_r;
  logic [CH_W-1:0]      out_channel_r;
  logic                 overrun_r;

  logic                 hs_s;
  logic                 last_ch_s;
  logic [CH_W-1:0]      nxt_ch_s;
  logic                 load_s;
  logic                 ovr_set_s;

  assign start_s = (state_r == IDLE) && enable && (period_cnt_r == CNT_W'(0));

  // Sample-period counter; parked at zero while sampling is disabled.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      period_cnt_r <= CNT_W'(0);
    end else if (!enable) begin
      period_cnt_r <= CNT_W'(0);
    end else if (period_cnt_r == CNT_W'(PERIOD_CYCLES - 1)) begin
      period_cnt_r <= CNT_W'(0);
    end else begin
      period_cnt_r <= period_cnt_r + CNT_W'(1);
    end
  end

  // FSM state and in-state clock counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= IDLE;
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: each non-idle state lasts a fixed number of clocks.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = NULLS;
          cnt_s   = CNT_W'(0);
        end else begin
          state_s = IDLE;
        end
      end
      NULLS: begin
        if (cnt_r == CNT_W'(NULL_BITS - 1)) begin
          state_s = SHIFT;
          cnt_s   = CNT_W'(0);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(DATA_BITS - 1)) begin
          state_s = GAP;
          cnt_s   = CNT_W'(0);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
          state_s = IDLE;
          cnt_s   = CNT_W'(0);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_W'(0);
      end
    endcase
  end

  // FSM outputs; cs follows the next state so it toggles on the same edge as the transition.
  always_comb begin
    cs_s       = 1'b1;
    shift_en_s = 1'b0;
    complete_s = 1'b0;
    case (state_s)
      NULLS, SHIFT: cs_s = 1'b0;
      IDLE, GAP:    cs_s = 1'b1;
      default:      cs_s = 1'b1;
    endcase
    if (state_r == SHIFT) begin
      shift_en_s = 1'b1;
      complete_s = (cnt_r == CNT_W'(DATA_BITS - 1));
    end else begin
      shift_en_s = 1'b0;
      complete_s = 1'b0;
    end
  end

  // Word as it stands after this clock's bit, so completion sees the final LSB.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      word_s[i] = {shreg_r[i][DATA_BITS-2:0], adc_data[i]};
    end
  end

  assign hs_s      = out_valid_r & out_ready;
  assign last_ch_s = (out_channel_r == CH_W'(NUM_CH - 1));
  assign nxt_ch_s  = out_channel_r + CH_W'(1);
  assign load_s    = complete_s & (~out_valid_r | (hs_s & last_ch_s));
  assign ovr_set_s = complete_s & ~load_s;

  // Per-channel input shift registers, all clocked together to keep samples aligned.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shreg_r[i] <= DATA_BITS'(0);
      end
    end else if (shift_en_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shreg_r[i] <= word_s[i];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shreg_r[i] <= shreg_r[i];
      end
    end
  end

  // Output buffer and drain sequencing; a full buffer is never overwritten.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_CH; i++) begin
        buf_r[i] <= DATA_BITS'(0);
      end
      out_valid_r   <= 1'b0;
      out_data_r    <= DATA_BITS'(0);
      out_channel_r <= CH_W'(0);
    end else if (load_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        buf_r[i] <= word_s[i];
      end
      out_valid_r   <= 1'b1;
      out_data_r    <= word_s[0];
      out_channel_r <= CH_W'(0);
    end else if (hs_s) begin
      if (last_ch_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_channel_r <= nxt_ch_s;
        out_data_r    <= buf_r[nxt_ch_s];
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Chip-select, busy and sticky overrun flag; a new overrun beats a clear.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cs_r      <= 1'b1;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      cs_r   <= cs_s;
      busy_r <= ~cs_s;
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign cs          = cs_r;
  assign busy        = busy_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_channel = out_channel_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_adc_frame_controller.sv
// Scoreboard bench for adc_frame_controller with emulated serial ADCs on every data line.
module tb_adc_frame_controller;
  localparam int NUM_CH = 4;
  localparam int DATA_BITS = 10;
  localparam int NULL_BITS = 3;
  localparam int GAP_CYCLES = 2;
  localparam int PERIOD_CYCLES = 20;
  localparam int CS_LOW = NULL_BITS + DATA_BITS;

  logic clk = 1'b0;
  logic reset_b, enable, ovr_clr, out_ready;
  logic [NUM_CH-1:0] adc_data;
  logic cs, busy, out_valid, overrun;
  logic [DATA_BITS-1:0] out_data;
  logic [1:0] out_channel;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];
  int hs_q[$];
  int falls_q[$];
  int fall_c = 0;
  logic prev_cs = 1'b1;
  logic abort_ok = 1'b0;
  logic [DATA_BITS-1:0] frame_vals [NUM_CH];

  adc_frame_controller #(
    .NUM_CH(NUM_CH), .DATA_BITS(DATA_BITS), .NULL_BITS(NULL_BITS),
    .GAP_CYCLES(GAP_CYCLES), .PERIOD_CYCLES(PERIOD_CYCLES)
  ) dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .ovr_clr(ovr_clr),
    .adc_data(adc_data), .cs(cs), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC emulators: bit for edge E(k+1) is presented shortly after edge E(k); nulls read as ones.
  initial begin
    int edge_n;
    int j;
    logic [DATA_BITS-1:0] cur_vals [NUM_CH];
    edge_n = 0;
    adc_data = '1;
    forever begin
      @(posedge clk);
      #1;
      if (cs === 1'b0) begin
        if (edge_n == 0) cur_vals = frame_vals;
        j = edge_n - NULL_BITS;
        if (j >= 0 && j < DATA_BITS) begin
          for (int ch = 0; ch < NUM_CH; ch++) adc_data[ch] = cur_vals[ch][DATA_BITS-1-j];
        end else begin
          adc_data = '1;
        end
        edge_n = edge_n + 1;
      end else begin
        edge_n = 0;
        adc_data = '1;
      end
    end
  end

  // Output monitor: every accepted word is popped against the scoreboard.
  always @(negedge clk) begin
    int got;
    if (reset_b && out_valid && out_ready) begin
      got = int'(out_channel) * 1024 + int'(out_data);
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_word", got, -1);
      else check("drain_word", got, exp_q.pop_front());
    end
  end

  // Chip-select monitor: records falls and checks every completed low pulse length.
  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      falls_q.push_back(cyc);
      fall_c = cyc;
    end
    if (!prev_cs && cs && !abort_ok) check("cs_low_len", cyc - fall_c, CS_LOW);
    prev_cs = cs;
  end

  task automatic push_frame();
    for (int ch = 0; ch < NUM_CH; ch++) exp_q.push_back(ch * 1024 + int'(frame_vals[ch]));
  endtask

  task automatic start_frame();
    int ok;
    ok = 0;
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (cs === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check("cs_fall_timeout", ok, 1);
  endtask

  task automatic wait_valid();
    int ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    check("valid_timeout", ok, 1);
  endtask

  task automatic wait_drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check("drain_timeout", ok, 1);
  endtask

  initial begin
    int any_valid;
    reset_b = 1'b0; enable = 1'b0; ovr_clr = 1'b0; out_ready = 1'b1;
    frame_vals = '{10'h2AA, 10'h155, 10'h3FF, 10'h001};

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_cs", int'(cs), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_channel", int'(out_channel), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1 reset_b = 1'b1;
    repeat (50) @(posedge clk);
    check("idle_no_cs_fall", falls_q.size(), 0);

    // Single frame, latency and back-to-back drain
    #1;
    falls_q.delete(); hs_q.delete();
    push_frame();
    start_frame();
    enable = 1'b0;
    check("busy_in_frame", int'(busy), 1);
    wait_drain();
    check("single_hs_count", hs_q.size(), NUM_CH);
    if (hs_q.size() == NUM_CH && falls_q.size() == 1) begin
      check("first_word_latency", hs_q[0] - falls_q[0], CS_LOW);
      for (int k = 1; k < NUM_CH; k++) check("consecutive_words", hs_q[k] - hs_q[0], k);
    end

    // Periodic sampling for 100 clocks
    repeat (10) @(posedge clk);
    #1;
    falls_q.delete();
    frame_vals = '{10'h0C3, 10'h2F0, 10'h10F, 10'h3C3};
    for (int f = 0; f < 5; f++) push_frame();
    enable = 1'b1;
    repeat (100) @(posedge clk);
    #1 enable = 1'b0;
    wait_drain();
    check("periodic_frames", falls_q.size(), 5);
    for (int k = 1; k < falls_q.size(); k++) check("cs_period", falls_q[k] - falls_q[k-1], PERIOD_CYCLES);
    check("periodic_no_overrun", int'(overrun), 0);

    // Backpressure
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b0;
    frame_vals = '{10'h123, 10'h0F0, 10'h2C3, 10'h3A5};
    push_frame();
    start_frame();
    enable = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", int'(out_channel) * 1024 + int'(out_data), 10'h123);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Overrun: second frame dropped while the first is stalled
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b0;
    frame_vals = '{10'h011, 10'h322, 10'h133, 10'h244};
    push_frame();
    start_frame();
    enable = 1'b0;
    wait_valid();
    check("ovr_before", int'(overrun), 0);
    repeat (4) @(posedge clk);
    #1;
    frame_vals = '{10'h3EE, 10'h0DD, 10'h2CC, 10'h1BB};
    start_frame();
    enable = 1'b0;
    repeat (CS_LOW + 1) @(negedge clk);
    check("ovr_set", int'(overrun), 1);
    check("ovr_buf_kept", int'(out_channel) * 1024 + int'(out_data), 10'h011);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr_clr", int'(overrun), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Enable dropped at E5: frame still delivered, nothing further starts
    repeat (10) @(posedge clk);
    #1;
    falls_q.delete();
    frame_vals = '{10'h2B4, 10'h1A7, 10'h05A, 10'h3C6};
    push_frame();
    start_frame();
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    wait_drain();
    repeat (40) @(posedge clk);
    check("abort_single_fall", falls_q.size(), 1);

    // Reset at E8: cs released at once, partial frame never appears
    #1;
    abort_ok = 1'b1;
    frame_vals = '{10'h155, 10'h2AA, 10'h0FF, 10'h300};
    start_frame();
    repeat (8) @(posedge clk);
    #1 reset_b = 1'b0;
    #1;
    check("mid_reset_cs", int'(cs), 1);
    check("mid_reset_busy", int'(busy), 0);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    any_valid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) any_valid = 1;
    end
    check("mid_reset_no_valid", any_valid, 0);
    abort_ok = 1'b0;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_frame_controller.md
# adc_frame_controller

Sequences simultaneous conversions on NUM_CH LTC1197-class serial ADCs (one per hydrophone) that share a single SPI clock and a single chip-select, each returning data on its own line. Drives `cs` on a fixed sample period and shifts all data lines in parallel. Delivers the captured words one channel at a time over a valid/ready stream to downstream logging/FIFO logic. Replaces ad-hoc counter/SIPO glue, and keeps channel samples time-aligned, which TDOA processing requires.

## Interface
- `NUM_CH`, 4, number of ADCs / data lines (2..8)
- `DATA_BITS`, 10, conversion width, MSB first
- `NULL_BITS`, 3, clocks after `cs` falls before the MSB is valid
- `GAP_CYCLES`, 2, minimum `cs`-high clocks between frames (≥1)
- `PERIOD_CYCLES`, 20, clocks between frame starts; must be ≥ 1+NULL_BITS+DATA_BITS+GAP_CYCLES
- `clk`  in  1  SPI clock, also drives the ADCs; all logic on posedge
- `reset_b`  in  1  asynchronous, active-low reset
- `enable`  in  1  1 = periodic sampling runs
- `ovr_clr`  in  1  single-cycle pulse; clears `overrun`
- `adc_data`  in  NUM_CH  serial data from ADC i on bit i
- `cs`  out  1  shared active-low chip-select, registered
- `busy`  out  1  1 while a frame is in progress (`cs` low)
- `out_valid`  out  1  `out_data`/`out_channel` hold a word
- `out_ready`  in  1  downstream accepts the word when `out_valid & out_ready`
- `out_data`  out  DATA_BITS  captured sample
- `out_channel`  out  clog2(NUM_CH)  channel index of `out_data`
- `overrun`  out  1  sticky: a completed frame was dropped

## Operation
- Period counter: 0..PERIOD_CYCLES-1, wraps. Held at 0 while `enable`=0. A frame starts when the counter is 0, `enable`=1 and the state is IDLE.
- FSM states: IDLE, NULLS, SHIFT, GAP.
  - IDLE: `cs`=1. On frame start, go to NULLS and drive `cs`=0.
  - NULLS: hold NULL_BITS clocks, ignoring `adc_data`. Then go to SHIFT.
  - SHIFT: on each of DATA_BITS clocks, shift `adc_data[i]` into the per-channel shift register i, MSB first. After the last bit, drive `cs`=1, run frame completion, and go to GAP.
  - GAP: hold GAP_CYCLES clocks with `cs`=1, then go to IDLE.
- Deasserting `enable` mid-frame does not abort the frame. The frame finishes and is delivered normally; no further frames start.
- Frame completion:
  - If the output buffer is empty, or becomes empty on this same cycle's handshake, load all NUM_CH words. Set `out_valid`=1 and `out_channel`=0.
  - Otherwise, discard the new frame and set `overrun`=1. The buffered frame is left untouched.
- Drain: each handshake advances to the next channel. The handshake on channel NUM_CH-1 clears `out_valid` and empties the buffer. `out_data`/`out_channel` stay stable while `out_valid & !out_ready`.
- `ovr_clr` clears `overrun`. If a new overrun happens on the same cycle, set wins.
- `busy` = (`cs`==0).

## Timing
- Reset values: `cs`=1, `busy`=0, `out_valid`=0, `out_data`=0, `out_channel`=0, `overrun`=0. FSM=IDLE, period counter=0, buffer empty.
- Edge E0 (frame start): `cs` goes low.
- Edges E1..E(NULL_BITS): null clocks.
- Edges E(NULL_BITS+1)..E(NULL_BITS+DATA_BITS): data sampled. The ADC changes data about 68 ns after posedge at a 140 ns period, so each bit is stable at the next posedge.
- Edge E(NULL_BITS+DATA_BITS): last bit sampled. `cs` returns to 1 and `out_valid` rises on this same edge (when the buffer is empty).
- `cs` low time is exactly 1+NULL_BITS+DATA_BITS-1 clocks = 13 with defaults.
- Minimum latency from frame start to the first word: NULL_BITS+DATA_BITS clocks.
- Maximum drain rate: one word per clock with `out_ready` held at 1.
- `reset_b` asserted mid-frame: immediate return to reset values, `cs`=1 asynchronously. A partial frame is never output.

## Test plan
- Reset/idle: hold `reset_b`=0 for 3 clocks, `enable`=0 → `cs`=1 and all outputs 0. Hold for 50 clocks → `cs` never falls.
- Single frame: `enable`=1, `out_ready`=1, emulators return 10'h2AA, 10'h155, 10'h3FF, 10'h001 on ch0..3 → `cs` low for exactly 13 clocks. Outputs are (ch0,2AA), (ch1,155), (ch2,3FF), (ch3,001) on 4 consecutive clocks.
- Periodic: `enable`=1 for 100 clocks → `cs` falling edges exactly 20 clocks apart. Each low pulse is 13 clocks, with ≥2 high clocks between pulses.
- Backpressure: `out_ready`=0 for 5 clocks after `out_valid` → `out_data`/`out_channel` hold (ch0, value). Releasing `out_ready` resumes ch0..3 in order.
- Overrun: hold `out_ready`=0 across two frames → `overrun`=1 and the first frame's words are preserved. Pulse `ovr_clr` → `overrun`=0.
- Abort/enable: deassert `enable` at E5 → frame completes, all 4 words are delivered, no further `cs` fall. Assert `reset_b`=0 at E8 of another frame → `cs`=1 immediately and `out_valid` stays 0.
